ascon_perm_ctrl: RTL and testbench

- Iterative sequencer for the ASCON permutation p^n over the 320-bit state x0..x4.
- Accepts a state and a round count over a valid/ready handshake.
- Applies one or two rounds per clock: constant addition, then the 64-wide S-box substitution layer, then the linear diffusion layer.
- Returns the permuted state over a second valid/ready handshake.
- Sits between the AEAD/hash mode FSM and the round datapath. It is the only owner of the permutation state register.

---
 rtl/ascon_pkg.sv | 36 +++
 rtl/ascon_round.sv | 53 +++++
 rtl/ascon_perm_ctrl.sv | 108 ++++++++++
 tb/tb_ascon_perm_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared constants, types and helpers for the ASCON permutation sequencer.
// Holds the state geometry, rotation amounts, round constants and FSM encoding.
package ascon_pkg;

    localparam int ASCON_STATE_W    = 320;
    localparam int ASCON_WORD_W     = 64;
    localparam int ASCON_MAX_ROUNDS = 12;

    // Linear-layer rotate-right amounts, one pair per state word.
    localparam int ROT_X0_A = 19;
    localparam int ROT_X0_B = 28;
    localparam int ROT_X1_A = 61;
    localparam int ROT_X1_B = 39;
    localparam int ROT_X2_A = 1;
    localparam int ROT_X2_B = 6;
    localparam int ROT_X3_A = 10;
    localparam int ROT_X3_B = 17;
    localparam int ROT_X4_A = 7;
    localparam int ROT_X4_B = 41;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ascon_fsm_t;

    function automatic logic [7:0] ascon_rc(input logic [3:0] i);
        return {4'hF - i, i};
    endfunction

    function automatic logic [ASCON_WORD_W-1:0] rotr(input logic [ASCON_WORD_W-1:0] v,
                                                     input int unsigned n);
        return (v >> n) | (v << (ASCON_WORD_W - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bitsliced 5-bit S-box
// layer across all 64 columns, then the per-word linear diffusion layer.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [ASCON_STATE_W-1:0] state,
    input  logic [3:0]               round_idx,
    output logic [ASCON_STATE_W-1:0] next_state
);

    logic [ASCON_WORD_W-1:0] x0, x1, x2, x3, x4;
    logic [ASCON_WORD_W-1:0] a0, a1, a2, a3, a4;
    logic [ASCON_WORD_W-1:0] t0, t1, t2, t3, t4;
    logic [ASCON_WORD_W-1:0] b0, b1, b2, b3, b4;
    logic [ASCON_WORD_W-1:0] s0, s1, s2, s3, s4;

    always_comb begin
        x0 = state[319:256];
        x1 = state[255:192];
        x2 = state[191:128] ^ {56'b0, ascon_rc(round_idx)};
        x3 = state[127:64];
        x4 = state[63:0];

        // Substitution layer, bitsliced: every bit column goes through the 5-bit S-box.
        a0 = x0 ^ x4;
        a1 = x1;
        a2 = x2 ^ x1;
        a3 = x3;
        a4 = x4 ^ x3;
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        b0 = a0 ^ t1;
        b1 = a1 ^ t2;
        b2 = a2 ^ t3;
        b3 = a3 ^ t4;
        b4 = a4 ^ t0;
        s1 = b1 ^ b0;
        s0 = b0 ^ b4;
        s3 = b3 ^ b2;
        s2 = ~b2;
        s4 = b4;

        next_state = {s0 ^ rotr(s0, ROT_X0_A) ^ rotr(s0, ROT_X0_B),
                      s1 ^ rotr(s1, ROT_X1_A) ^ rotr(s1, ROT_X1_B),
                      s2 ^ rotr(s2, ROT_X2_A) ^ rotr(s2, ROT_X2_B),
                      s3 ^ rotr(s3, ROT_X3_A) ^ rotr(s3, ROT_X3_B),
                      s4 ^ rotr(s4, ROT_X4_A) ^ rotr(s4, ROT_X4_B)};
    end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative ASCON p^n sequencer: accepts a state and round count, applies RPC
// rounds per clock from the owned state register, and returns the result.
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int RPC        = 1,
    parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               rounds,
    input  logic [ASCON_STATE_W-1:0] state_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ASCON_STATE_W-1:0] state_out,
    output logic                     busy
);

    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    ascon_fsm_t              fsm;
    logic [ASCON_STATE_W-1:0] state_reg;
    logic [3:0]               r;
    logic [3:0]               n_eff;
    logic [4:0]               r_sum;
    logic [3:0]               r_next;
    logic                     accept;
    logic [ASCON_STATE_W-1:0] stage0;
    logic [ASCON_STATE_W-1:0] round_next;

    assign n_eff    = (rounds > MAX_R) ? MAX_R : rounds;
    assign r_sum    = {1'b0, r} + 5'(RPC);
    assign r_next   = (r_sum >= 5'(MAX_ROUNDS)) ? MAX_R : r_sum[3:0];
    assign in_ready = (fsm == IDLE) || ((fsm == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign state_out = state_reg;

    ascon_round u_round0 (
        .state      (state_reg),
        .round_idx  (r),
        .next_state (stage0)
    );

    // Second cascaded round is bypassed when it would run past the last index (odd n).
    if (RPC == 2) begin : g_rpc2
        logic [ASCON_STATE_W-1:0] stage1;
        logic [3:0]               r_plus1;
        assign r_plus1 = r + 4'd1;
        ascon_round u_round1 (
            .state      (stage0),
            .round_idx  (r_plus1),
            .next_state (stage1)
        );
        assign round_next = (r_plus1 >= MAX_R) ? stage0 : stage1;
    end else if (RPC == 1) begin : g_rpc1
        assign round_next = stage0;
    end else begin : g_bad_rpc
        $error("ascon_perm_ctrl: RPC must be 1 or 2");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            state_reg <= '0;
            r         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE, DONE: begin
                    if (accept) begin
                        state_reg <= state_in;
                        r         <= MAX_R - n_eff;
                        if (n_eff == 4'd0) begin
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            fsm       <= RUN;
                            out_valid <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end else if ((fsm == DONE) && out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                RUN: begin
                    state_reg <= round_next;
                    r         <= r_next;
                    if (r_next == MAX_R) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: RPC=1 and RPC=2 instances checked
// against a table-driven column-wise ASCON permutation model.
module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         sel;
    logic [3:0]   rounds;
    logic [319:0] state_in;

    logic         iv1, iv2, or1, or2;
    logic         in_ready1, out_valid1, busy1;
    logic         in_ready2, out_valid2, busy2;
    logic [319:0] state_out1, state_out2;
    logic         ir, ov, bz;
    logic [319:0] so;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    assign iv1 = in_valid & ~sel;
    assign iv2 = in_valid & sel;
    assign or1 = out_ready & ~sel;
    assign or2 = out_ready & sel;
    assign ir  = sel ? in_ready2  : in_ready1;
    assign ov  = sel ? out_valid2 : out_valid1;
    assign bz  = sel ? busy2      : busy1;
    assign so  = sel ? state_out2 : state_out1;

    ascon_perm_ctrl #(.RPC(1), .MAX_ROUNDS(12)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1), .rounds(rounds),
        .state_in(state_in), .out_valid(out_valid1), .out_ready(or1),
        .state_out(state_out1), .busy(busy1));

    ascon_perm_ctrl #(.RPC(2), .MAX_ROUNDS(12)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(in_ready2), .rounds(rounds),
        .state_in(state_in), .out_valid(out_valid2), .out_ready(or2),
        .state_out(state_out2), .busy(busy2));

    always #5 clk = ~clk;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] model_round(input logic [319:0] s, input int i);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col, o;
        for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
        x[2] = x[2] ^ 64'(((15 - i) << 4) | i);
        for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = SBOX[col];
            y[0][b] = o[4];
            y[1][b] = o[3];
            y[2][b] = o[2];
            y[3][b] = o[1];
            y[4][b] = o[0];
        end
        for (int k = 0; k < 5; k++) y[k] = y[k] ^ rotr(y[k], ROT_A[k]) ^ rotr(y[k], ROT_B[k]);
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
        int ne;
        logic [319:0] v;
        ne = (n > 12) ? 12 : n;
        v = s;
        for (int i = 12 - ne; i < 12; i++) v = model_round(v, i);
        return v;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] v;
        v = '0;
        for (int k = 0; k < 10; k++) v = {v[287:0], 32'($urandom())};
        return v;
    endfunction

    task automatic drain(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_drain: out_valid=%b in_ready=%b required 0/1", name, ov, ir);
        end
    endtask

    task automatic run_job(input logic [319:0] s, input logic [3:0] n, input string name);
        logic [319:0] exp_s;
        int exp_lat, ne, rpc, waited, busy_cnt;
        rpc = sel ? 2 : 1;
        ne = (n > 4'd12) ? 12 : int'(n);
        exp_lat = (ne + rpc - 1) / rpc;
        exp_s = model_perm(s, int'(n));
        @(negedge clk);
        in_valid = 1'b1;
        rounds = n;
        state_in = s;
        out_ready = 1'b0;
        #1;
        checks++;
        if (ir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_in_ready: got %b required 1", name, ir);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        busy_cnt = 0;
        while (ov !== 1'b1 && waited < 40) begin
            if (bz === 1'b1) busy_cnt++;
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited != exp_lat) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d cycles required %0d", name, waited, exp_lat);
        end
        checks++;
        if (busy_cnt != exp_lat) begin
            errors++;
            $display("[TB] FAIL %s_busy_cycles: got %0d required %0d", name, busy_cnt, exp_lat);
        end
        checks++;
        if (so !== exp_s) begin
            errors++;
            $display("[TB] FAIL %s_state: got %h required %h", name, so, exp_s);
        end
        drain(name);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rounds = '0;
        state_in = '0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = (d == 1);
            #1;
            checks++;
            if (ir !== 1'b1 || ov !== 1'b0 || bz !== 1'b0 || so !== '0) begin
                errors++;
                $display("[TB] FAIL reset_values_rpc%0d: in_ready=%b out_valid=%b busy=%b state_nonzero=%b required 1/0/0/0",
                         d + 1, ir, ov, bz, |so);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_p12_zero;
        sel = 1'b0;
        run_job('0, 4'd12, "p12_zero");
    endtask

    task automatic test_init_state;
        logic [319:0] iv_state;
        iv_state = {64'h80400c0600000000, 256'h0};
        sel = 1'b0;
        run_job(iv_state, 4'd6, "p6_iv");
        run_job(iv_state, 4'd8, "p8_iv");
    endtask

    task automatic test_passthrough;
        logic [319:0] pat;
        pat = {5{64'h0123456789ABCDEF}};
        sel = 1'b0;
        run_job(pat, 4'd0, "p0_passthrough");
        run_job(pat, 4'd15, "p15_clamp");
    endtask

    task automatic test_back_to_back;
        logic [319:0] s1, s2, held, exp2;
        int waited;
        sel = 1'b0;
        s1 = rand_state();
        s2 = rand_state();
        exp2 = model_perm(s2, 8);
        @(negedge clk);
        in_valid = 1'b1;
        rounds = 4'd6;
        state_in = s1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (ov !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        held = so;
        checks++;
        if (held !== model_perm(s1, 6)) begin
            errors++;
            $display("[TB] FAIL bp_first_state: got %h required %h", held, model_perm(s1, 6));
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (ov !== 1'b1 || so !== held || ir !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold_cycle%0d: out_valid=%b in_ready=%b state_stable=%b required 1/0/1",
                         c, ov, ir, so === held);
            end
            @(negedge clk);
        end
        in_valid = 1'b1;
        rounds = 4'd8;
        state_in = s2;
        out_ready = 1'b1;
        #1;
        checks++;
        if (ir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_b2b_in_ready: got %b required 1", ir);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (bz !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_b2b_busy: busy=%b out_valid=%b required 1/0", bz, ov);
        end
        waited = 0;
        while (ov !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited != 8 || so !== exp2) begin
            errors++;
            $display("[TB] FAIL bp_second_job: latency %0d required 8, state got %h required %h",
                     waited, so, exp2);
        end
        drain("bp_second");
    endtask

    task automatic test_async_reset;
        int seen;
        sel = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        rounds = 4'd12;
        state_in = rand_state();
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ir !== 1'b1 || ov !== 1'b0 || bz !== 1'b0 || so !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset_values: in_ready=%b out_valid=%b busy=%b state_nonzero=%b required 1/0/0/0",
                     ir, ov, bz, |so);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (ov === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL async_reset_aborted: out_valid seen=%0d required 0", seen);
        end
        run_job(rand_state(), 4'd12, "p12_after_reset");
    endtask

    task automatic test_rpc2;
        logic [319:0] iv_state;
        iv_state = {64'h80400c0600000000, 256'h0};
        sel = 1'b1;
        run_job('0, 4'd12, "rpc2_p12_zero");
        run_job(iv_state, 4'd6, "rpc2_p6_iv");
        run_job(rand_state(), 4'd7, "rpc2_p7_odd");
        run_job(iv_state, 4'd0, "rpc2_p0");
        sel = 1'b0;
    endtask

    task automatic test_random;
        for (int j = 0; j < 8; j++) begin
            sel = j[0];
            run_job(rand_state(), 4'($urandom_range(0, 15)), $sformatf("rand%0d", j));
        end
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_p12_zero();
        test_init_state();
        test_passthrough();
        test_back_to_back();
        test_async_reset();
        test_rpc2();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
